// File: rtl/trace_trigger_unit.sv
// Trace trigger unit: watches a flit stream for a masked pattern and drives the
// trace buffer write port for the trigger flit plus a programmed number of followers.
module trace_trigger_unit #(
    parameter int Fpay     = 32,
    parameter int CNT_W    = 9,
    parameter int TB_WORDS = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Fpay-1:0]  flit_in,
    input  logic             flit_valid,
    input  logic [Fpay-1:0]  match_val,
    input  logic [Fpay-1:0]  match_mask,
    input  logic [CNT_W-1:0] post_count,
    input  logic             arm,
    input  logic             stop,
    output logic [Fpay-1:0]  trace,
    output logic             trigger,
    output logic [1:0]       state_o,
    output logic             done,
    output logic             overflow,
    output logic [CNT_W:0]   wr_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [CNT_W:0] CapWords = (CNT_W+1)'(TB_WORDS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W:0]   wr_count_q, wr_count_d;
    logic [Fpay-1:0]  trace_q, trace_d;
    logic             trigger_q, trigger_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;

    logic             flit_match;
    logic             write_en;
    logic [CNT_W:0]   wr_count_inc;
    logic             cap_hit;
    logic             last_word;

    // stop and arm both pre-empt any write on the edge they are sampled
    assign flit_match   = flit_valid & (((flit_in ^ match_val) & match_mask) == '0);
    assign write_en     = !stop && !arm &&
                          (((state_q == ARMED) && flit_match) ||
                           ((state_q == CAPTURE) && flit_valid));
    assign wr_count_inc = wr_count_q + (CNT_W+1)'(1);
    assign cap_hit      = (wr_count_inc >= CapWords);
    assign last_word    = (state_q == ARMED) ? (post_count == '0)
                                             : (remaining_q <= CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            wr_count_q  <= '0;
            trace_q     <= '0;
            trigger_q   <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wr_count_q  <= wr_count_d;
            trace_q     <= trace_d;
            trigger_q   <= trigger_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d = ARMED;
        end else if (write_en && (cap_hit || last_word)) begin
            state_d = DONE;
        end else if (write_en && (state_q == ARMED)) begin
            state_d = CAPTURE;
        end
    end

    always_comb begin
        remaining_d = remaining_q;
        wr_count_d  = wr_count_q;
        trace_d     = trace_q;
        trigger_d   = write_en;
        overflow_d  = overflow_q;
        done_d      = (state_d == DONE);
        if (stop) begin
            overflow_d = 1'b0;
        end else if (arm) begin
            wr_count_d = '0;
            overflow_d = 1'b0;
        end else if (write_en) begin
            trace_d    = flit_in;
            wr_count_d = wr_count_inc;
            overflow_d = cap_hit;
            if (state_q == ARMED) begin
                remaining_d = post_count;
            end else if (remaining_q != '0) begin
                remaining_d = remaining_q - CNT_W'(1);
            end
        end
    end

    assign trace    = trace_q;
    assign trigger  = trigger_q;
    assign state_o  = state_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign wr_count = wr_count_q;

endmodule
